// File: rtl/spike_event_packer_pkg.sv
// Shared definitions for the spike event packer: event word layout,
// scan FSM encoding and the word packing helper.
package spike_pkg;

    localparam int EVT_W     = 8;
    localparam int SPIKE_BIT = 7;
    localparam int CLASS_MSB = 6;
    localparam int CLASS_LSB = 5;
    localparam int CH_MSB    = 4;

    // Widest channel index the word can carry (32 channels).
    localparam int CH_W      = CH_MSB + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Build one event word: [7]=spike, [6:5]=class, [4:0]=channel index.
    function automatic logic [EVT_W-1:0] pack_event(input logic            spike,
                                                    input logic [1:0]      cls,
                                                    input logic [CH_W-1:0] ch);
        logic [EVT_W-1:0] word;
        word                       = '0;
        word[SPIKE_BIT]            = spike;
        word[CLASS_MSB:CLASS_LSB]  = cls;
        word[CH_MSB:0]             = ch;
        return word;
    endfunction

endpackage

// File: rtl/spike_event_packer_if.sv
// Byte-wide event output stream.
// Handshake: a word transfers on a clock edge where out_valid and out_ready
// are both high. The master holds out_data stable while out_valid is high and
// out_ready is low; out_ready while out_valid is low has no effect.
interface spike_event_packer_if;
    import spike_pkg::*;

    logic [EVT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/spike_event_packer_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter. A push while
// full is refused even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty     = (wptr == rptr);
    assign level     = wptr - rptr;
    assign head_data = mem[rptr[AW-1:0]];
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;

    // Storage and pointer update; reset clears the array so the head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_event_packer.sv
// Snapshots the per-channel spike/event arrays on each sample_valid strobe,
// walks the channels one per cycle in ascending order and queues one event
// word for every active channel. Dropped words and dropped frames are counted
// and flagged so loss is always visible.
module spike_event_packer
    import spike_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        spike_detection_array,
    input  logic [2*NUM_UNITS-1:0]      event_out_array,
    input  logic                        sample_valid,
    input  logic                        clear_flags,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        overflow,
    output logic                        frame_overrun,
    output logic [7:0]                  drop_count,
    output scan_state_t                 state_dbg,
    spike_event_packer_if.master        out_bus
);

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_UNITS - 1);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [CH_W-1:0]  idx_q;

    // Snapshots are widened to the full 32-channel range so the 5-bit scan
    // index always addresses a real bit.
    logic [31:0]      spk_q;
    logic [63:0]      evt_q;

    logic             cur_spike;
    logic [1:0]       cur_cls;
    logic             cur_active;
    logic [EVT_W-1:0] push_word;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    logic             frame_drop;
    logic             push_drop;
    logic [1:0]       drop_inc;
    logic [7:0]       drop_base;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_next;

    assign cur_spike  = spk_q[idx_q];
    assign cur_cls    = evt_q[{idx_q, 1'b0} +: 2];
    assign cur_active = cur_spike | (cur_cls != 2'b00);
    assign push_word  = pack_event(cur_spike, cur_cls, idx_q);

    assign busy       = (state_q == SCAN);
    assign state_dbg  = state_q;

    assign out_bus.out_valid = ~fifo_empty;
    assign pop               = out_bus.out_valid & out_bus.out_ready;

    // A new strobe during a scan loses that whole frame; a push into a full
    // FIFO loses that word. Both can happen in the same cycle.
    assign frame_drop = sample_valid & busy;
    assign push_drop  = push & fifo_full;
    assign drop_inc   = {1'b0, frame_drop} + {1'b0, push_drop};

    // Clear is applied before this cycle's drops, then the count saturates.
    assign drop_base  = clear_flags ? 8'd0 : drop_count;
    assign drop_sum   = {1'b0, drop_base} + {7'd0, drop_inc};
    assign drop_next  = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    // Scan FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and push request: one channel is examined per SCAN cycle.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                push = cur_active;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the input arrays on an accepted strobe and step the scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            spk_q <= '0;
            evt_q <= '0;
            idx_q <= '0;
        end else if ((state_q == IDLE) && sample_valid) begin
            spk_q <= 32'(spike_detection_array);
            evt_q <= 64'(event_out_array);
            idx_q <= '0;
        end else if (state_q == SCAN) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    // Sticky loss flags and the saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow      <= 1'b0;
            frame_overrun <= 1'b0;
            drop_count    <= '0;
        end else begin
            overflow      <= (overflow & ~clear_flags) | push_drop;
            frame_overrun <= (frame_overrun & ~clear_flags) | frame_drop;
            drop_count    <= drop_next;
        end
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head_data (out_bus.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed bench for spike_event_packer (NUM_UNITS=4, FIFO_DEPTH=8).
module tb_spike_event_packer;
    import spike_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  spk = '0;
    logic [7:0]  evt = '0;
    logic        sv  = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  lvl;
    logic        busy;
    logic        ovf;
    logic        fovr;
    logic [7:0]  dcnt;
    scan_state_t st;

    spike_event_packer_if bus ();

    spike_event_packer #(
        .NUM_UNITS  (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .spike_detection_array (spk),
        .event_out_array       (evt),
        .sample_valid          (sv),
        .clear_flags           (clr),
        .fifo_level            (lvl),
        .busy                  (busy),
        .overflow              (ovf),
        .frame_overrun         (fovr),
        .drop_count            (dcnt),
        .state_dbg             (st),
        .out_bus               (bus)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    logic        rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every accepted word must match the queue head, and data
    // must hold while the consumer stalls.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("pop_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall <= bus.out_valid & ~bus.out_ready;
            prev_data  <= bus.out_data;
        end
    end

    // Driver tasks: everything moves at 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [3:0] s, input logic [7:0] e);
        spk = s;
        evt = e;
        sv  = 1'b1;
        tick();
        sv  = 1'b0;
        spk = '0;
        evt = '0;
    endtask

    task automatic count_busy(output int nb, output int nv);
        nb = 0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) nb++;
            if (bus.out_valid) nv++;
            tick();
        end
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && k < 300) begin
            tick();
            k++;
        end
        check(tag, 32'(k < 300), 32'd1);
    endtask

    task automatic model_frame(input logic [3:0] s, input logic [7:0] e);
        logic [1:0] cls;
        for (int ch = 0; ch < 4; ch++) begin
            cls = e[2*ch +: 2];
            if (s[ch] || cls != 2'b00) exp_q.push_back({s[ch], cls, 5'(ch)});
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int nb;
        int nv;
        int k;
        logic [3:0] rs;
        logic [7:0] re;

        bus.out_ready = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_level", 32'(lvl), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({ovf, fovr}), 32'd0);
        check("rst_drops", 32'(dcnt), 32'd0);
        check("rst_state", 32'(st), 32'(IDLE));

        // 1: two active channels -> 0xA0 then 0xC2.
        bus.out_ready = 1'b1;
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hC2);
        send_frame(4'b0101, 8'b00_10_00_01);
        check("t1_state", 32'(st), 32'(SCAN));
        count_busy(nb, nv);
        check("t1_busy_cycles", 32'(nb), 32'd4);
        wait_drain("t1_drain");
        check("t1_level", 32'(lvl), 32'd0);

        // 2: empty frame still scans, produces nothing.
        send_frame(4'b0000, 8'h00);
        count_busy(nb, nv);
        check("t2_busy_cycles", 32'(nb), 32'd4);
        check("t2_no_valid", 32'(nv), 32'd0);
        check("t2_flags", 32'({ovf, fovr}), 32'd0);
        check("t2_drops", 32'(dcnt), 32'd0);

        // 3: stalled consumer, 12 words offered to 8 entries.
        bus.out_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            send_frame(4'hF, 8'h00);
            repeat (5) tick();
        end
        check("t3_level_full", 32'(lvl), 32'd8);
        check("t3_overflow", 32'(ovf), 32'd1);
        check("t3_drops", 32'(dcnt), 32'd4);
        check("t3_overrun", 32'(fovr), 32'd0);
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < 4; ch++) exp_q.push_back(8'h80 | 8'(ch));
        end
        bus.out_ready = 1'b1;
        wait_drain("t3_drain");
        check("t3_level_empty", 32'(lvl), 32'd0);
        check("t3_overflow_sticky", 32'(ovf), 32'd1);
        do_clear();
        check("t3_clear_flags", 32'({ovf, fovr}), 32'd0);
        check("t3_clear_drops", 32'(dcnt), 32'd0);

        // 4: second strobe two cycles after the first is dropped.
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h81);
        send_frame(4'b0011, 8'h00);
        tick();
        send_frame(4'hF, 8'hFF);
        check("t4_overrun", 32'(fovr), 32'd1);
        check("t4_drops", 32'(dcnt), 32'd1);
        check("t4_overflow", 32'(ovf), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        repeat (6) tick();
        wait_drain("t4_drain");
        check("t4_level", 32'(lvl), 32'd0);
        do_clear();

        // 5: random back-pressure over 50 frames, paced so nothing drops.
        rand_rdy = 1'b1;
        for (int f = 0; f < 50; f++) begin
            k = 0;
            while ((busy || lvl > 4) && k < 100) begin
                tick();
                k++;
            end
            check("t5_pace", 32'(k < 100), 32'd1);
            rs = 4'($urandom_range(0, 15));
            re = 8'($urandom_range(0, 255));
            model_frame(rs, re);
            send_frame(rs, re);
        end
        repeat (5) tick();
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain("t5_drain");
        check("t5_flags", 32'({ovf, fovr}), 32'd0);
        check("t5_drops", 32'(dcnt), 32'd0);

        // 6a: reset mid-scan with three words queued.
        bus.out_ready = 1'b0;
        send_frame(4'b0111, 8'h00);
        repeat (5) tick();
        check("t6_level3", 32'(lvl), 32'd3);
        send_frame(4'hF, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_level", 32'(lvl), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_state", 32'(st), 32'(IDLE));

        // 6b: clear_flags in the same cycle as a word drop.
        for (int f = 0; f < 2; f++) begin
            send_frame(4'hF, 8'h00);
            repeat (5) tick();
        end
        check("t6_full", 32'(lvl), 32'd8);
        send_frame(4'b0001, 8'h00);
        repeat (5) tick();
        check("t6_pre_drops", 32'(dcnt), 32'd1);
        send_frame(4'b0001, 8'h00);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_clr_drop_count", 32'(dcnt), 32'd1);
        check("t6_clr_drop_ovf", 32'(ovf), 32'd1);
        repeat (4) tick();
        check("t6_drops_after", 32'(dcnt), 32'd1);
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < 4; ch++) exp_q.push_back(8'h80 | 8'(ch));
        end
        bus.out_ready = 1'b1;
        wait_drain("t6_drain");
        check("t6_level_end", 32'(lvl), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
